// File: rtl/vga_fb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : vga_fb_pkg                                                  |
// | Purpose    : Shared types and default sizes for the VGA framebuffer     |
// |              access scheduler and its clear-screen sequencer.           |
// | Contents   : owner_t     - owner tag of an in-flight RAM read           |
// |              clr_state_t - clear sequencer states                       |
// |              FB_DEPTH_DEF / DATA_W_DEF - default geometry (320x240 RGB332)|
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package vga_fb_pkg;

  localparam int FB_DEPTH_DEF = 76800;
  localparam int DATA_W_DEF   = 8;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_SCAN  = 2'd1,
    OWN_DRAW  = 2'd2,
    OWN_CLEAR = 2'd3
  } owner_t;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_t;

endpackage : vga_fb_pkg
`default_nettype wire

// File: rtl/vga_fb_clear_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : vga_fb_clear_seq                                            |
// | Purpose    : Clear-screen sequencer. Walks every framebuffer word once,  |
// |              writing a colour latched at start. Advances only when the   |
// |              scheduler grants its write request.                         |
// | Ports      : clk, rst_n        - clock, async active-low reset           |
// |              start, color      - start pulse and fill colour            |
// |              gnt               - write granted this cycle              |
// |              req, addr, data   - write request towards the scheduler    |
// |              busy, done        - pass in progress / completion pulse    |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module vga_fb_clear_seq
  import vga_fb_pkg::*;
#(
  parameter int FB_DEPTH = FB_DEPTH_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = $clog2(FB_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] color,
  input  logic              gnt,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done
);

  clr_state_t state;
  clr_state_t state_nxt;
  logic       last;

  assign last = (addr == ADDR_W'(FB_DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLR_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A start pulse during a pass is ignored because only IDLE looks at it.
  always_comb begin
    state_nxt = state;
    case (state)
      CLR_IDLE:  if (start)       state_nxt = CLR_CLEAR;
      CLR_CLEAR: if (gnt && last) state_nxt = CLR_IDLE;
      default:                    state_nxt = CLR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      data <= '0;
      done <= 1'b0;
    end else begin
      // done lands in the first IDLE cycle, the same cycle busy drops.
      done <= (state == CLR_CLEAR) && gnt && last;
      if ((state == CLR_IDLE) && start) begin
        addr <= '0;
        data <= color;
      end else if ((state == CLR_CLEAR) && gnt) begin
        addr <= addr + ADDR_W'(1);
      end
    end
  end

  assign req  = (state == CLR_CLEAR);
  assign busy = (state == CLR_CLEAR);

endmodule : vga_fb_clear_seq
`default_nettype wire

// File: rtl/vga_fb_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : vga_fb_scheduler                                            |
// | Purpose    : Shares one synchronous single-port pixel RAM between the    |
// |              VGA scan-out reader, a valid/ready draw port and an         |
// |              optional clear-screen sequencer. Priority: scan>clear>draw. |
// | Ports      : CLOCK_50, reset_n           - clock, async active-low reset |
// |              scan_req/addr, scan_rvalid/rdata   - scan-out read port     |
// |              drw_valid/ready/we/addr/wdata, drw_rvalid/rdata - draw port |
// |              clear_start/color, clear_busy/done - clear-screen control   |
// |              mem_addr/we/wdata, mem_rdata       - RAM port (1-cycle read)|
// | Options    : FB_CLEAR_EN - compiles in the clear sequencer; otherwise    |
// |              clear_start/clear_color are ignored and busy/done are 0.    |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module vga_fb_scheduler
  import vga_fb_pkg::*;
#(
  parameter int FB_DEPTH = FB_DEPTH_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = $clog2(FB_DEPTH)
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_rvalid,
  output logic [DATA_W-1:0] scan_rdata,
  input  logic              drw_valid,
  output logic              drw_ready,
  input  logic              drw_we,
  input  logic [ADDR_W-1:0] drw_addr,
  input  logic [DATA_W-1:0] drw_wdata,
  output logic              drw_rvalid,
  output logic [DATA_W-1:0] drw_rdata,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              clr_req;
  logic              clr_gnt;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_data;
  logic              scan_gnt;
  logic              drw_fire;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] wdata_hold;
  owner_t            owner;
  owner_t            owner_nxt;

`ifdef FB_CLEAR_EN
  vga_fb_clear_seq #(
    .FB_DEPTH (FB_DEPTH),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W)
  ) u_clear_seq (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .start (clear_start),
    .color (clear_color),
    .gnt   (clr_gnt),
    .req   (clr_req),
    .addr  (clr_addr),
    .data  (clr_data),
    .busy  (clear_busy),
    .done  (clear_done)
  );
`else
  assign clr_req    = 1'b0;
  assign clr_addr   = '0;
  assign clr_data   = '0;
  assign clear_busy = 1'b0;
  assign clear_done = 1'b0;

  logic unused_clear;
  assign unused_clear = ^{clear_start, clear_color, clr_gnt};
`endif

  // Grants are qualified by reset_n so the RAM port and drw_ready sit at
  // their idle values for the whole time reset is held, not only after it.
  assign scan_gnt  = reset_n && scan_req;
  assign clr_gnt   = reset_n && clr_req && !scan_req;
  assign drw_ready = reset_n && !scan_req && !clear_busy;
  assign drw_fire  = drw_valid && drw_ready;

  always_comb begin
    mem_addr  = addr_hold;
    mem_we    = 1'b0;
    mem_wdata = wdata_hold;
    owner_nxt = OWN_NONE;
    if (scan_gnt) begin
      mem_addr  = scan_addr;
      owner_nxt = OWN_SCAN;
    end else if (clr_gnt) begin
      mem_addr  = clr_addr;
      mem_we    = 1'b1;
      mem_wdata = clr_data;
    end else if (drw_fire) begin
      mem_addr = drw_addr;
      mem_we   = drw_we;
      if (drw_we) begin
        mem_wdata = drw_wdata;
      end else begin
        owner_nxt = OWN_DRAW;
      end
    end
  end

  // The owner tag travels with the read for one cycle, so in the cycle the
  // RAM presents data it is steered into the right requester's register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      addr_hold   <= '0;
      wdata_hold  <= '0;
      owner       <= OWN_NONE;
      scan_rvalid <= 1'b0;
      scan_rdata  <= '0;
      drw_rvalid  <= 1'b0;
      drw_rdata   <= '0;
    end else begin
      addr_hold   <= mem_addr;
      wdata_hold  <= mem_wdata;
      owner       <= owner_nxt;
      scan_rvalid <= (owner == OWN_SCAN);
      drw_rvalid  <= (owner == OWN_DRAW);
      if (owner == OWN_SCAN) scan_rdata <= mem_rdata;
      if (owner == OWN_DRAW) drw_rdata  <= mem_rdata;
    end
  end

endmodule : vga_fb_scheduler
`default_nettype wire

// File: tb/tb_vga_fb_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_vga_fb_scheduler                                         |
// | Purpose    : Self-checking bench for vga_fb_scheduler with a 16-word     |
// |              framebuffer and a behavioural single-port RAM. Read data   |
// |              and latency are checked against a scoreboard queue.        |
// | Options    : FB_CLEAR_EN selects the clear-sequencer scenarios.         |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_vga_fb_scheduler;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       scan_req;
  logic [3:0] scan_addr;
  logic       scan_rvalid;
  logic [7:0] scan_rdata;
  logic       drw_valid;
  logic       drw_ready;
  logic       drw_we;
  logic [3:0] drw_addr;
  logic [7:0] drw_wdata;
  logic       drw_rvalid;
  logic [7:0] drw_rdata;
  logic       clear_start;
  logic [7:0] clear_color;
  logic       clear_busy;
  logic       clear_done;
  logic [3:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] ram   [DEPTH];
  logic [7:0] model [DEPTH];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } sb_t;
  sb_t sq[$];
  sb_t dq[$];

  typedef struct {
    bit       sreq;
    bit [3:0] saddr;
    bit       dv;
    bit       dwe;
    bit [3:0] daddr;
    bit [7:0] dwd;
    bit       exp_ready;
    bit       exp_we;
    bit [3:0] exp_addr;
  } vec_t;
  vec_t tbl [12];

  vga_fb_scheduler #(
    .FB_DEPTH (DEPTH),
    .DATA_W   (8)
  ) dut (
    .CLOCK_50    (clk),
    .reset_n     (reset_n),
    .scan_req    (scan_req),
    .scan_addr   (scan_addr),
    .scan_rvalid (scan_rvalid),
    .scan_rdata  (scan_rdata),
    .drw_valid   (drw_valid),
    .drw_ready   (drw_ready),
    .drw_we      (drw_we),
    .drw_addr    (drw_addr),
    .drw_wdata   (drw_wdata),
    .drw_rvalid  (drw_rvalid),
    .drw_rdata   (drw_rdata),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Read-return monitor: every rvalid must match the oldest expected read,
  // arriving exactly two cycles after its issue cycle.
  always @(negedge clk) begin
    if (sq.size() > 0 && sq[0].cyc + 2 < cyc) begin
      chk("scan_missing_rvalid", 32'(cyc), 32'(sq[0].cyc + 2));
      void'(sq.pop_front());
    end
    if (dq.size() > 0 && dq[0].cyc + 2 < cyc) begin
      chk("drw_missing_rvalid", 32'(cyc), 32'(dq[0].cyc + 2));
      void'(dq.pop_front());
    end
    if (scan_rvalid) begin
      if (sq.size() == 0) begin
        chk("scan_unexpected_rvalid", 32'(scan_rvalid), 32'd0);
      end else begin
        sb_t e;
        e = sq.pop_front();
        chk("scan_rdata", 32'(scan_rdata), 32'(e.data));
        chk("scan_latency", 32'(cyc), 32'(e.cyc + 2));
      end
    end
    if (drw_rvalid) begin
      if (dq.size() == 0) begin
        chk("drw_unexpected_rvalid", 32'(drw_rvalid), 32'd0);
      end else begin
        sb_t e;
        e = dq.pop_front();
        chk("drw_rdata", 32'(drw_rdata), 32'(e.data));
        chk("drw_latency", 32'(cyc), 32'(e.cyc + 2));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit sreq, input bit [3:0] saddr, input bit dv,
                       input bit dwe, input bit [3:0] da, input bit [7:0] dd);
    scan_req  = sreq;
    scan_addr = saddr;
    drw_valid = dv;
    drw_we    = dwe;
    drw_addr  = da;
    drw_wdata = dd;
  endtask

  // Called at the negedge of an issue cycle: checks drw_ready against the
  // bench's expectation and books reads / model writes accordingly.
  task automatic book(input bit exp_ready);
    chk("drw_ready", 32'(drw_ready), 32'(exp_ready));
    if (scan_req) sq.push_back('{model[scan_addr], cyc});
    if (drw_valid && exp_ready) begin
      if (drw_we) model[drw_addr] = drw_wdata;
      else        dq.push_back('{model[drw_addr], cyc});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef FB_CLEAR_EN
  task automatic run_clear(input bit [7:0] color, input bit with_scan, input int ignore_at,
                           output int busy_n, output int done_n);
    int p;
    bit fin;
    p      = 0;
    fin    = 1'b0;
    busy_n = 0;
    done_n = 0;
    drive(0, 0, 0, 0, 0, 0);
    clear_start = 1'b1;
    clear_color = color;
    @(negedge clk);
    chk("busy_on_start", 32'(clear_busy), 32'd0);
    step();
    clear_start = 1'b0;
    clear_color = 8'h00;
    for (int k = 1; k < 200 && !fin; k++) begin
      scan_req  = with_scan && (k % 2 == 1);
      scan_addr = k[3:0];
      if (k == ignore_at) begin
        clear_start = 1'b1;
        clear_color = ~color;
      end else begin
        clear_start = 1'b0;
      end
      @(negedge clk);
      if (scan_req) sq.push_back('{model[scan_addr], cyc});
      if (clear_busy) begin
        busy_n++;
        chk("ready_in_clear", 32'(drw_ready), 32'd0);
        if (scan_req) begin
          chk("clr_yield_we", 32'(mem_we), 32'd0);
          chk("clr_yield_addr", 32'(mem_addr), 32'(scan_addr));
        end else begin
          chk("clr_we", 32'(mem_we), 32'd1);
          chk("clr_addr", 32'(mem_addr), 32'(p[3:0]));
          model[p[3:0]] = color;
          p++;
        end
      end
      if (clear_done) begin
        done_n++;
        fin = 1'b1;
      end
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    clear_start = 1'b0;
    @(negedge clk);
    chk("done_one_pulse", 32'(clear_done), 32'd0);
    step();
    for (int i = 0; i < DEPTH; i++) chk("clear_word", 32'(ram[i]), 32'(color));
  endtask
`endif

  initial begin
    int busy_n;
    int done_n;
    reset_n     = 1'b0;
    clear_start = 1'b0;
    clear_color = 8'h00;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_scan_rvalid", 32'(scan_rvalid), 32'd0);
    chk("rst_scan_rdata",  32'(scan_rdata),  32'd0);
    chk("rst_drw_rvalid",  32'(drw_rvalid),  32'd0);
    chk("rst_drw_rdata",   32'(drw_rdata),   32'd0);
    chk("rst_clear_busy",  32'(clear_busy),  32'd0);
    chk("rst_clear_done",  32'(clear_done),  32'd0);
    chk("rst_mem_we",      32'(mem_we),      32'd0);
    chk("rst_mem_addr",    32'(mem_addr),    32'd0);
    chk("rst_mem_wdata",   32'(mem_wdata),   32'd0);
    chk("rst_drw_ready",   32'(drw_ready),   32'd0);
    reset_n = 1'b1;
    step();

    // Fill every word with a distinct value through the draw port.
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 1, 1, 4'(i), 8'(16 + i * 8));
      @(negedge clk);
      book(1'b1);
      step();
    end

    tbl[0]  = '{0, 4'd0,  0, 0, 4'd0,  8'h00, 1, 0, 4'd15};
    tbl[1]  = '{0, 4'd0,  1, 1, 4'd5,  8'hA5, 1, 1, 4'd5};
    tbl[2]  = '{1, 4'd10, 0, 0, 4'd0,  8'h00, 0, 0, 4'd10};
    tbl[3]  = '{1, 4'd11, 1, 0, 4'd5,  8'h00, 0, 0, 4'd11};
    tbl[4]  = '{0, 4'd0,  1, 0, 4'd5,  8'h00, 1, 0, 4'd5};
    tbl[5]  = '{1, 4'd12, 0, 0, 4'd0,  8'h00, 0, 0, 4'd12};
    tbl[6]  = '{0, 4'd0,  1, 1, 4'd15, 8'h3C, 1, 1, 4'd15};
    tbl[7]  = '{1, 4'd13, 1, 1, 4'd7,  8'hEE, 0, 0, 4'd13};
    tbl[8]  = '{0, 4'd0,  0, 0, 4'd0,  8'h00, 1, 0, 4'd13};
    tbl[9]  = '{0, 4'd0,  1, 0, 4'd15, 8'h00, 1, 0, 4'd15};
    tbl[10] = '{1, 4'd14, 0, 0, 4'd0,  8'h00, 0, 0, 4'd14};
    tbl[11] = '{0, 4'd0,  1, 0, 4'd7,  8'h00, 1, 0, 4'd7};
    for (int r = 0; r < 12; r++) begin
      drive(tbl[r].sreq, tbl[r].saddr, tbl[r].dv, tbl[r].dwe, tbl[r].daddr, tbl[r].dwd);
      @(negedge clk);
      chk($sformatf("row%0d_mem_we", r), 32'(mem_we), 32'(tbl[r].exp_we));
      chk($sformatf("row%0d_mem_addr", r), 32'(mem_addr), 32'(tbl[r].exp_addr));
      if (tbl[r].exp_we) chk($sformatf("row%0d_mem_wdata", r), 32'(mem_wdata), 32'(tbl[r].dwd));
      book(tbl[r].exp_ready);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();

    // Reset while a draw read is in flight: its data must be discarded.
    drive(0, 0, 1, 0, 4'd5, 8'h00);
    @(negedge clk);
    chk("inflight_ready", 32'(drw_ready), 32'd1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("midread_drw_rvalid", 32'(drw_rvalid), 32'd0);
    chk("midread_mem_addr", 32'(mem_addr), 32'd0);
    repeat (2) step();
    chk("midread_drw_rdata", 32'(drw_rdata), 32'd0);
    reset_n = 1'b1;
    repeat (3) step();

`ifdef FB_CLEAR_EN
    run_clear(8'h1F, 1'b0, 5, busy_n, done_n);
    chk("clear_busy_cycles", 32'(busy_n), 32'd16);
    chk("clear_done_count", 32'(done_n), 32'd1);

    run_clear(8'h5A, 1'b1, 0, busy_n, done_n);
    chk("clear_scan_busy_cycles", 32'(busy_n), 32'd32);
    chk("clear_scan_done_count", 32'(done_n), 32'd1);
    repeat (3) step();

    // Reset after 7 clear writes with a scan read in flight.
    clear_start = 1'b1;
    clear_color = 8'h77;
    step();
    clear_start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("rst_clear_busy_pre", 32'(clear_busy), 32'd1);
      model[k - 1] = 8'h77;
      step();
    end
    drive(1, 4'd9, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("midclr_busy", 32'(clear_busy), 32'd0);
    chk("midclr_scan_rvalid", 32'(scan_rvalid), 32'd0);
    chk("midclr_mem_we", 32'(mem_we), 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    chk("midclr_word6", 32'(ram[6]), 32'h77);
    chk("midclr_word7", 32'(ram[7]), 32'h5A);
    run_clear(8'h11, 1'b0, 0, busy_n, done_n);
    chk("reclear_busy_cycles", 32'(busy_n), 32'd16);
`else
    clear_start = 1'b1;
    clear_color = 8'h1F;
    for (int k = 0; k < 20; k++) begin
      drive(k % 2 == 0, k[3:0], 0, 0, 0, 0);
      if (k > 0) clear_start = 1'b0;
      @(negedge clk);
      chk("noclr_busy", 32'(clear_busy), 32'd0);
      chk("noclr_done", 32'(clear_done), 32'd0);
      chk("noclr_mem_we", 32'(mem_we), 32'd0);
      book(k % 2 != 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    clear_start = 1'b0;
`endif

    repeat (4) step();
    chk("scan_queue_empty", 32'(sq.size()), 32'd0);
    chk("drw_queue_empty", 32'(dq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_vga_fb_scheduler
`default_nettype wire

// File: doc/vga_fb_scheduler.md
# vga_fb_scheduler

Single-port framebuffer access scheduler for the VGA display path. It shares one synchronous single-port pixel RAM between three users:
- the VGA scan-out reader, which is hard real-time and never stalled;
- a draw engine, which uses a valid/ready port for reads and writes;
- an optional built-in clear-screen sequencer.

The block sits between the VGA timing/pixel pipeline and the framebuffer RAM. It runs on the 50 MHz system clock; scan requests arrive at the 25 MHz pixel rate.

## Interface
Parameters:
- FB_DEPTH, 76800 — framebuffer words (320x240)
- DATA_W, 8 — pixel width (RGB332)
- ADDR_W, $clog2(FB_DEPTH) — address width

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset (top level drives it from KEY[0])
- scan_req  in  1  scan-out read request; must be honoured the same cycle
- scan_addr  in  ADDR_W  scan read address
- scan_rvalid  out  1  scan read data valid
- scan_rdata  out  DATA_W  scan read data
- drw_valid  in  1  draw request valid
- drw_ready  out  1  draw request accepted this cycle
- drw_we  in  1  1 = write, 0 = read
- drw_addr  in  ADDR_W  draw address
- drw_wdata  in  DATA_W  draw write data
- drw_rvalid  out  1  draw read data valid
- drw_rdata  out  DATA_W  draw read data
- clear_start  in  1  pulse: start a clear-screen pass
- clear_color  in  DATA_W  fill value, sampled on the accepted clear_start
- clear_busy  out  1  clear pass in progress
- clear_done  out  1  one-cycle pulse when a pass completes
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data; valid one cycle after the address

## Operation
- Fixed priority each cycle: scan > clear > draw.
- mem_addr, mem_we and mem_wdata are a combinational mux of the cycle's winner. With no winner: mem_we=0 and mem_addr holds its last value.
- Scan:
  - scan_req is always granted; it is never stalled or dropped.
  - Back-to-back scan_req is legal.
- Draw:
  - drw_ready = !scan_req && !clear_busy.
  - A transfer occurs when drw_valid && drw_ready.
  - The requester must hold its request stable until accepted.
- Read ownership:
  - A one-cycle owner tag (NONE/SCAN/DRAW) follows every read issue.
  - In the next cycle, mem_rdata is registered into the owner's rdata, and that owner's rvalid is set for exactly one cycle.
  - rdata holds its value between reads.
- Clear FSM, states IDLE and CLEAR:
  - IDLE→CLEAR on clear_start. This loads clr_addr=0 and latches clear_color.
  - In CLEAR, every cycle without scan_req writes the latched colour to clr_addr, then increments clr_addr.
  - CLEAR→IDLE on the cycle after the write to FB_DEPTH-1. clear_done pulses in that cycle.
  - clear_start while busy is ignored.
- Reset (any time, including mid-clear or mid-read):
  - FSM goes to IDLE; clr_addr=0; owner tag=NONE.
  - All outputs take their reset values. The in-flight read's data is discarded.

## Timing
- Reset values: scan_rvalid=0, scan_rdata=0, drw_rvalid=0, drw_rdata=0, clear_busy=0, clear_done=0, mem_we=0, mem_addr=0, mem_wdata=0.
- drw_ready during reset is 0.
- Read latency: request issued in cycle t; rvalid and rdata appear in cycle t+2.
- Write: performed at the rising edge ending the issue cycle.
- clear_busy rises the cycle after the accepted clear_start. It falls together with the clear_done pulse.
- Minimum clear duration is FB_DEPTH cycles. With scan_req every other cycle it is ≈2·FB_DEPTH cycles.
- Draw worst-case wait:
  - outside a clear: 1 cycle when scan runs at its 1-in-2 rate;
  - during a clear: the full clear duration.

## Configuration
- FB_CLEAR_EN defined: clear FSM, clear_color latch and clr_addr counter are compiled in, as described above.
- FB_CLEAR_EN undefined:
  - clear FSM, clear_color latch and clr_addr counter are removed; clear_start and clear_color are ignored;
  - clear_busy and clear_done are tied 0;
  - drw_ready = !scan_req.

## Structure
- Package vga_fb_pkg contains:
  - owner_t enum (OWN_NONE, OWN_SCAN, OWN_DRAW, OWN_CLEAR);
  - clr_state_t enum (CLR_IDLE, CLR_CLEAR);
  - default FB_DEPTH/DATA_W constants.
- One sub-module, vga_fb_clear_seq: the clear FSM and address counter. It presents a request/grant pair to the scheduler and is instantiated only under FB_CLEAR_EN.
- The scheduler top holds the arbitration mux and the read-owner tag pipeline.

## Test plan
- Scan + draw read contention: scan_req every other cycle (addr 100, 101, …); drw read of addr 5 (RAM holds 0xA5) raised on a scan cycle → drw_ready=0 that cycle, accepted next cycle; drw_rvalid with 0xA5 exactly 2 cycles after acceptance; scan data uncorrupted.
- Draw write then read: write 0x3C to addr 76799, then read it → drw_rdata=0x3C; mem_we high only in the write issue cycle.
- Clear with FB_DEPTH=16, clear_color=0x1F, no scan → clear_busy high 16 cycles, clear_done one pulse, all 16 words = 0x1F; drw_ready=0 throughout; a second clear_start mid-pass is ignored.
- Clear with scan_req every other cycle → clear takes 32 cycles; scan reads all return on time.
- Reset asserted mid-clear (after 7 writes) and during an in-flight scan read → no rvalid pulse; clear_busy=0 immediately; after release, a new clear starts at addr 0.
- Build without FB_CLEAR_EN: pulse clear_start → clear_busy and clear_done stay 0; drw_ready tracks !scan_req.
